// File: rtl/peripheral_gpio_arb_pkg.sv
// Shared types and defaults for the round-robin APB4 GPIO arbiter.
// Timeout support is enabled by defining PERIPHERAL_GPIO_ARB_TIMEOUT_EN.
package peripheral_gpio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int DEF_PDATA_SIZE     = 8;
  localparam int DEF_PSTRB_SIZE     = DEF_PDATA_SIZE / 8;
  localparam int DEF_PADDR_SIZE     = 4;
  localparam int DEF_N_REQ          = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam int MAX_REQ            = 8;

  // Index of the set bit in a one-hot vector (0 when empty).
  function automatic logic [2:0] onehot_index(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/peripheral_gpio_apb4_arbiter_if.sv
// APB4 bus between the arbiter (master) and the shared GPIO slave.
interface peripheral_gpio_apb4_arbiter_if #(
  parameter int PDATA_SIZE = 8,
  parameter int PADDR_SIZE = 4
);
  localparam int PSTRB_SIZE = PDATA_SIZE / 8;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [PADDR_SIZE-1:0] PADDR;
  logic [PDATA_SIZE-1:0] PWDATA;
  logic [PSTRB_SIZE-1:0] PSTRB;
  logic [PDATA_SIZE-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/peripheral_gpio_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module peripheral_gpio_rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic             valid
);

  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!valid && req[k] && (((int'(ptr) + i) % N_REQ) == k)) begin
          grant[k] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/peripheral_gpio_apb4_arbiter.sv
// Round-robin APB4 master sharing one GPIO slave among N_REQ requesters.
// Optional ACCESS timeout: define PERIPHERAL_GPIO_ARB_TIMEOUT_EN.
module peripheral_gpio_apb4_arbiter
  import peripheral_gpio_arb_pkg::*;
#(
  parameter int PDATA_SIZE     = DEF_PDATA_SIZE,
  parameter int PADDR_SIZE     = DEF_PADDR_SIZE,
  parameter int N_REQ          = DEF_N_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ-1:0]              req_write_i,
  input  logic [N_REQ*PADDR_SIZE-1:0]   req_addr_i,
  input  logic [N_REQ*PDATA_SIZE-1:0]   req_wdata_i,
  input  logic [N_REQ*PDATA_SIZE/8-1:0] req_strb_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic [N_REQ-1:0]              done_o,
  output logic [PDATA_SIZE-1:0]         rdata_o,
  output logic                          err_o,
  peripheral_gpio_apb4_arbiter_if.master apb
);

  localparam int PSTRB_SIZE = PDATA_SIZE / 8;
  localparam int PTR_W      = $clog2(N_REQ);

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      ptr, ptr_adv, arb_ptr;
  logic [N_REQ-1:0]      owner, arb_mask, win;
  logic                  win_vld, complete, load, timed_out, busy;
  logic [2:0]            own_idx;

  logic                  lat_write;
  logic [PADDR_SIZE-1:0] lat_addr, sel_addr;
  logic [PDATA_SIZE-1:0] lat_wdata, sel_wdata;
  logic [PSTRB_SIZE-1:0] lat_strb, sel_strb;
  logic                  sel_write;

  assign busy     = (state != IDLE);
  assign complete = (state == ACCESS) && (apb.PREADY || timed_out);
  assign own_idx  = onehot_index(MAX_REQ'(owner));

  always_comb begin
    ptr_adv = (int'(own_idx) == N_REQ - 1) ? '0 : PTR_W'(int'(own_idx) + 1);
  end

  // The requester completing now and the one whose done pulse is showing
  // are both excluded, so a req_i still held during done_o is not re-served.
  assign arb_ptr  = complete ? ptr_adv : ptr;
  assign arb_mask = req_i & ~done_o & (complete ? ~owner : '1);

  peripheral_gpio_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (arb_mask),
    .ptr   (arb_ptr),
    .grant (win),
    .valid (win_vld)
  );

  assign load = win_vld && ((state == IDLE) || complete);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (complete) state_nxt = win_vld ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win[k]) begin
        sel_write = req_write_i[k];
        sel_addr  = req_addr_i[k*PADDR_SIZE +: PADDR_SIZE];
        sel_wdata = req_wdata_i[k*PDATA_SIZE +: PDATA_SIZE];
        sel_strb  = req_strb_i[k*PSTRB_SIZE +: PSTRB_SIZE];
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      done_o  <= '0;
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_o  <= complete ? owner : '0;
      rdata_o <= (complete && !lat_write && !timed_out) ? apb.PRDATA : '0;
      err_o   <= complete && (timed_out || apb.PSLVERR);
      if (complete) ptr <= ptr_adv;
      if (load)          owner <= win;
      else if (complete) owner <= '0;
    end
  end

  // Request fields are captured once per grant; write-only fields are zeroed for reads.
  always_ff @(posedge PCLK) begin
    if (load) begin
      lat_write <= sel_write;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_write ? sel_wdata : '0;
      lat_strb  <= sel_write ? sel_strb : '0;
    end
  end

`ifdef PERIPHERAL_GPIO_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge PCLK) begin
    if (!PRESETn || state != ACCESS) to_cnt <= '0;
    else                              to_cnt <= to_cnt + 1'b1;
  end

  assign timed_out = (state == ACCESS) && !apb.PREADY &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timed_out      = 1'b0;
`endif

  assign gnt_o       = owner;
  assign apb.PSEL    = busy;
  assign apb.PENABLE = (state == ACCESS);
  assign apb.PWRITE  = busy && lat_write;
  assign apb.PADDR   = busy ? lat_addr : '0;
  assign apb.PWDATA  = busy ? lat_wdata : '0;
  assign apb.PSTRB   = busy ? lat_strb : '0;

endmodule

// File: tb/tb_peripheral_gpio_apb4_arbiter.sv
// Directed bench for peripheral_gpio_apb4_arbiter with a behavioural GPIO register slave.
module tb_peripheral_gpio_apb4_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, req_write, gnt, done;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [7:0]  rdata;
  logic        err;
  logic        ready, slverr, mem_clr;
  logic [7:0]  mem [16];

  int n_cmp, n_bad;
  logic [3:0] ord [8];
  int n_done, last_cyc;
  bit gap;

  typedef struct {
    int         k;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       strb;
    logic       slverr;
    int         wait_n;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs [7];

  peripheral_gpio_apb4_arbiter_if #(.PDATA_SIZE(8), .PADDR_SIZE(4)) bus ();

  peripheral_gpio_apb4_arbiter #(
    .PDATA_SIZE(8), .PADDR_SIZE(4), .N_REQ(4), .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK        (clk),
    .PRESETn     (rst_n),
    .req_i       (req),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_strb_i  (req_strb),
    .gnt_o       (gnt),
    .done_o      (done),
    .rdata_o     (rdata),
    .err_o       (err),
    .apb         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file slave: zero-wait unless the bench lowers ready.
  assign bus.PREADY  = ready;
  assign bus.PSLVERR = slverr;
  assign bus.PRDATA  = bus.PSEL ? mem[bus.PADDR] : 8'h00;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE && bus.PSTRB[0]) begin
      mem[bus.PADDR] <= bus.PWDATA;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int lat;
    req_write[v.k]         = v.wr;
    req_addr[v.k*4 +: 4]   = v.addr;
    req_wdata[v.k*8 +: 8]  = v.wdata;
    req_strb[v.k]          = v.strb;
    slverr                 = v.slverr;
    ready                  = 1'b0;
    req[v.k]               = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_setup", id), {bus.PSEL, bus.PENABLE}, 2'b10);
    chk($sformatf("v%0d_paddr", id), bus.PADDR, v.addr);
    chk($sformatf("v%0d_pwrite", id), bus.PWRITE, v.wr);
    chk($sformatf("v%0d_pwdata", id), bus.PWDATA, v.wr ? v.wdata : 8'h00);
    chk($sformatf("v%0d_pstrb", id), bus.PSTRB, v.wr ? v.strb : 1'b0);
    chk($sformatf("v%0d_gnt", id), gnt, 4'b0001 << v.k);
    ready = (v.wait_n == 0);
    @(negedge clk);
    chk($sformatf("v%0d_access", id), {bus.PSEL, bus.PENABLE}, 2'b11);
    for (int w = 0; w < v.wait_n; w++) begin
      @(negedge clk);
      chk($sformatf("v%0d_hold_paddr", id), {bus.PSEL, bus.PENABLE, bus.PADDR}, {2'b11, v.addr});
      if (w == v.wait_n - 1) ready = 1'b1;
    end
    lat = 2 + v.wait_n;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      lat++;
      if (done != 4'b0000) break;
    end
    chk($sformatf("v%0d_latency", id), lat, 3 + v.wait_n);
    chk($sformatf("v%0d_done", id), done, 4'b0001 << v.k);
    chk($sformatf("v%0d_rdata", id), rdata, v.exp_rdata);
    chk($sformatf("v%0d_err", id), err, v.exp_err);
    chk($sformatf("v%0d_gnt_rel", id), {gnt, bus.PSEL}, 5'b0);
    req[v.k] = 1'b0;
    slverr   = 1'b0;
    ready    = 1'b1;
  endtask

  // Hold all requesters in mask until each sees its done pulse; records service order.
  task automatic serve_all(input logic [3:0] mask, input logic [7:0] exp_rdata, input string tag);
    bit started;
    started  = 1'b0;
    n_done   = 0;
    gap      = 1'b0;
    last_cyc = 0;
    ready    = 1'b1;
    req      = mask;
    for (int cyc = 1; cyc <= 24 && req != 4'b0000; cyc++) begin
      @(negedge clk);
      if (bus.PSEL) started = 1'b1;
      else if (started && (req & ~done) != 4'b0000) gap = 1'b1;
      if (done != 4'b0000) begin
        if (n_done < 8) ord[n_done] = done;
        n_done++;
        last_cyc = cyc;
        chk({tag, "_rdata"}, rdata, exp_rdata);
        req = req & ~done;
      end
    end
    chk({tag, "_all_served"}, req, 4'b0000);
    req = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 1'b1, 4'h1, 8'hA5, 1'b1, 1'b0, 0, 8'h00, 1'b0};
    vecs[1] = '{2, 1'b0, 4'h1, 8'hFF, 1'b1, 1'b0, 0, 8'hA5, 1'b0};
    vecs[2] = '{1, 1'b1, 4'h3, 8'h3C, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    vecs[3] = '{3, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    vecs[4] = '{1, 1'b1, 4'hF, 8'h5A, 1'b1, 1'b1, 0, 8'h00, 1'b1};
    vecs[5] = '{0, 1'b0, 4'hF, 8'h00, 1'b0, 1'b1, 1, 8'h5A, 1'b1};
    vecs[6] = '{3, 1'b0, 4'hF, 8'h00, 1'b0, 1'b0, 2, 8'h5A, 1'b0};

    n_cmp = 0; n_bad = 0;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    ready = 1'b1; slverr = 1'b0; mem_clr = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_apb", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, 0);
    chk("reset_ctrl", {gnt, done, rdata, err}, 0);
    mem_clr = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // All four contend with pointer at 0: 0,1,2,3 back-to-back.
    for (int k = 0; k < 4; k++) begin
      req_write[k] = 1'b0; req_addr[k*4 +: 4] = 4'h1; req_strb[k] = 1'b0;
    end
    @(negedge clk);
    serve_all(4'b1111, 8'hA5, "cont");
    chk("cont_count", n_done, 4);
    chk("cont_order", {ord[0], ord[1], ord[2], ord[3]}, 16'h1248);
    chk("cont_span", last_cyc, 9);
    chk("cont_no_idle", gap, 1'b0);

    // Serve requester 2 so the pointer sits at 3, then 0 and 3 contend.
    @(negedge clk);
    serve_all(4'b0100, 8'hA5, "pre_wrap");
    @(negedge clk);
    serve_all(4'b1001, 8'hA5, "wrap");
    chk("wrap_order", {ord[0], ord[1]}, 8'h81);
    chk("wrap_span", last_cyc, 5);

    // Reset during ACCESS aborts silently and clears the pointer.
    @(negedge clk);
    ready = 1'b0;
    req   = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_access", {bus.PSEL, bus.PENABLE}, 2'b11);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_abort_apb", {bus.PSEL, bus.PENABLE}, 2'b00);
    chk("rst_abort_gnt", gnt, 4'b0000);
    chk("rst_abort_done", done, 4'b0000);
    rst_n = 1'b1;
    req   = 4'b0000;
    ready = 1'b1;
    @(negedge clk);
    chk("rst_no_late_done", done, 4'b0000);
    serve_all(4'b0011, 8'hA5, "post_rst");
    chk("post_rst_order", {ord[0], ord[1]}, 8'h12);

`ifdef PERIPHERAL_GPIO_ARB_TIMEOUT_EN
    // Slave never ready: termination after 4 ACCESS cycles with error.
    begin
      int lat;
      @(negedge clk);
      ready = 1'b0;
      req   = 4'b0010;
      lat   = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        lat++;
        if (done != 4'b0000) break;
      end
      chk("to_latency", lat, 6);
      chk("to_done", done, 4'b0010);
      chk("to_err", err, 1'b1);
      chk("to_rdata", rdata, 8'h00);
      chk("to_bus_idle", {bus.PSEL, bus.PENABLE}, 2'b00);
      req   = 4'b0000;
      ready = 1'b1;
    end
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
